// File: rtl/bbc_kbd_pkg.sv
// Shared types and constants for the BBC micro keyboard matrix model.
package bbc_kbd_pkg;

   localparam int NUM_COLS       = 10;
   localparam int NUM_ROWS       = 8;
   localparam int LINK_COL_FIRST = 2;

   typedef logic [3:0] kbd_col_t;
   typedef logic [2:0] kbd_row_t;

   // Columns 10-15 exist on the 4-bit bus but have no keys behind them.
   function automatic logic col_valid(input kbd_col_t col);
      return col < kbd_col_t'(NUM_COLS);
   endfunction

   // Row 0 of columns 2-9 is wired to the startup option links, not to keys.
   function automatic logic is_link(input kbd_col_t col, input kbd_row_t row);
      return (row == '0) && (col >= kbd_col_t'(LINK_COL_FIRST));
   endfunction

endpackage

// File: rtl/bbc_kbd_scan_counter.sv
// Keyboard column counter: free-running mod-10 when enabled, otherwise
// follows the column the VIA drives on port A.
module bbc_kbd_scan_counter
   import bbc_kbd_pkg::*;
(
   input  logic     PHI_2,
   input  logic     nRESET,
   input  logic     AUTOSCAN,
   input  kbd_col_t load_col,
   output kbd_col_t COL_OUT
);

   // Count 0..9 in auto-scan; anything >= 9 (including loaded 10-15) wraps to 0.
   always_ff @(posedge PHI_2 or negedge nRESET) begin
      if (!nRESET)
         COL_OUT <= '0;
      else if (AUTOSCAN)
         COL_OUT <= (COL_OUT >= kbd_col_t'(NUM_COLS - 1)) ? '0 : COL_OUT + kbd_col_t'(1);
      else
         COL_OUT <= load_col;
   end

endmodule

// File: rtl/bbc_keyboard.sv
// BBC micro keyboard matrix behind the system VIA (port A / CA2).
// Optional: define BBC_KBD_ROLLOVER_EN to limit rows 1-7 to 8 keys held at once.
module bbc_keyboard
   import bbc_kbd_pkg::*;
#(
   parameter logic [7:0] LINKS = 8'h00
)(
   input  logic       PHI_2,
   input  logic       nRESET,
   input  logic       AUTOSCAN,
   input  logic [6:0] PA_SEL,
   output logic       PA7,
   output logic       CA2,
   input  logic       KEY_STB,
   input  logic       KEY_DOWN,
   input  logic [2:0] KEY_ROW,
   input  logic [3:0] KEY_COL,
   input  logic       KEY_CLR,
   output logic [3:0] COL_OUT
);

   logic [NUM_COLS-1:0][NUM_ROWS-1:0] key_q;
   logic [NUM_COLS-1:0][NUM_ROWS-1:0] key_v;
   kbd_col_t scan_col;
   kbd_col_t sel_col;
   kbd_row_t sel_row;
   logic     ev_ok;
   logic     ev_apply;

   assign sel_col = PA_SEL[3:0];
   assign sel_row = PA_SEL[6:4];

   bbc_kbd_scan_counter u_scan (
      .PHI_2    (PHI_2),
      .nRESET   (nRESET),
      .AUTOSCAN (AUTOSCAN),
      .load_col (sel_col),
      .COL_OUT  (scan_col)
   );

   assign COL_OUT = scan_col;

   // Visible matrix: link bits replace the unstored row-0 positions.
   always_comb begin
      key_v = key_q;
      for (int c = LINK_COL_FIRST; c < NUM_COLS; c++)
         key_v[c][0] = LINKS[c - LINK_COL_FIRST];
   end

   assign ev_ok = KEY_STB && col_valid(KEY_COL) && !is_link(KEY_COL, KEY_ROW);

`ifdef BBC_KBD_ROLLOVER_EN
   logic [3:0] down_cnt;
   logic       cur_key;

   assign cur_key = ev_ok && key_q[KEY_COL][KEY_ROW];

   // Only real transitions of rows 1-7 touch the count; a make that would be
   // the ninth held key is dropped, so its later break finds the key up.
   always_comb begin
      ev_apply = ev_ok;
      if (ev_ok && (KEY_ROW != '0)) begin
         if (KEY_DOWN)
            ev_apply = !cur_key && (down_cnt < 4'd8);
         else
            ev_apply = cur_key;
      end
   end

   // Held-key count for rows 1-7, bounded 0..8 by the gating above.
   always_ff @(posedge PHI_2 or negedge nRESET) begin
      if (!nRESET)
         down_cnt <= '0;
      else if (KEY_CLR)
         down_cnt <= '0;
      else if (ev_apply && (KEY_ROW != '0))
         down_cnt <= KEY_DOWN ? down_cnt + 4'd1 : down_cnt - 4'd1;
   end
`else
   assign ev_apply = ev_ok;
`endif

   // Key matrix update; clear wins over a same-cycle event.
   always_ff @(posedge PHI_2 or negedge nRESET) begin
      if (!nRESET)
         key_q <= '0;
      else if (KEY_CLR)
         key_q <= '0;
      else if (ev_apply)
         key_q[KEY_COL][KEY_ROW] <= KEY_DOWN;
   end

   // CA2: any key in rows 1-7 of the current column, one cycle late.
   always_ff @(posedge PHI_2 or negedge nRESET) begin
      if (!nRESET)
         CA2 <= 1'b0;
      else
         CA2 <= col_valid(scan_col) && (|key_q[scan_col][NUM_ROWS-1:1]);
   end

   assign PA7 = !AUTOSCAN && col_valid(sel_col) && key_v[sel_col][sel_row];

endmodule

// File: tb/tb_bbc_keyboard.sv
// Randomized + directed bench for bbc_keyboard against a behavioural key model.
module tb_bbc_keyboard;

   localparam logic [7:0] LINKS_TB = 8'hA5;

   logic       PHI_2 = 1'b0;
   logic       nRESET = 1'b1;
   logic       AUTOSCAN = 1'b1;
   logic [6:0] PA_SEL = '0;
   logic       PA7;
   logic       CA2;
   logic       KEY_STB = 1'b0;
   logic       KEY_DOWN = 1'b0;
   logic [2:0] KEY_ROW = '0;
   logic [3:0] KEY_COL = '0;
   logic       KEY_CLR = 1'b0;
   logic [3:0] COL_OUT;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   bit [7:0]   km [10];
   int         col_m;
   bit         ca2_m;
   logic [7:0] links_v;

   bbc_keyboard #(.LINKS(LINKS_TB)) dut (
      .PHI_2    (PHI_2),
      .nRESET   (nRESET),
      .AUTOSCAN (AUTOSCAN),
      .PA_SEL   (PA_SEL),
      .PA7      (PA7),
      .CA2      (CA2),
      .KEY_STB  (KEY_STB),
      .KEY_DOWN (KEY_DOWN),
      .KEY_ROW  (KEY_ROW),
      .KEY_COL  (KEY_COL),
      .KEY_CLR  (KEY_CLR),
      .COL_OUT  (COL_OUT)
   );

   always #5 PHI_2 = ~PHI_2;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   function automatic int keys_held();
      int n = 0;
      for (int c = 0; c < 10; c++)
         for (int r = 1; r < 8; r++)
            n += int'(km[c][r]);
      return n;
   endfunction

   function automatic int pa7_exp();
      int c = int'(PA_SEL[3:0]);
      int r = int'(PA_SEL[6:4]);
      if (AUTOSCAN || c > 9) return 0;
      if (r == 0 && c >= 2) return int'(links_v[c-2]);
      return int'(km[c][r]);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 10; c++) km[c] = '0;
      col_m = 0;
      ca2_m = 0;
   endtask

   // One rising edge of the spec's behaviour, from the inputs held this cycle.
   task automatic model_edge();
      bit ca2_n;
      bit ok;
      int c = int'(KEY_COL);
      int r = int'(KEY_ROW);
      ca2_n = (col_m <= 9) && (km[col_m][7:1] != 7'd0);
      if (KEY_CLR) begin
         for (int i = 0; i < 10; i++) km[i] = '0;
      end else if (KEY_STB && c <= 9 && !(r == 0 && c >= 2)) begin
         ok = 1;
`ifdef BBC_KBD_ROLLOVER_EN
         if (r != 0 && KEY_DOWN && !km[c][r] && keys_held() >= 8) ok = 0;
`endif
         if (ok) km[c][r] = KEY_DOWN;
      end
      if (AUTOSCAN) col_m = (col_m >= 9) ? 0 : col_m + 1;
      else          col_m = int'(PA_SEL[3:0]);
      ca2_m = ca2_n;
   endtask

   // Called at a falling edge with inputs already set.
   task automatic tick();
      #1;
      chk("pa7", int'(PA7), pa7_exp());
      @(posedge PHI_2);
      model_edge();
      @(negedge PHI_2);
      chk("ca2", int'(CA2), int'(ca2_m));
      chk("col", int'(COL_OUT), col_m);
      KEY_STB = 1'b0;
      KEY_CLR = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic ev(input bit down, input int row, input int col);
      KEY_STB  = 1'b1;
      KEY_DOWN = down;
      KEY_ROW  = 3'(row);
      KEY_COL  = 4'(col);
      tick();
   endtask

   initial begin
      links_v = LINKS_TB;
      model_reset();

      // reset state
      #2 nRESET = 1'b0;
      #1;
      chk("rst_col", int'(COL_OUT), 0);
      chk("rst_ca2", int'(CA2), 0);
      chk("rst_pa7", int'(PA7), 0);
      @(negedge PHI_2);
      nRESET = 1'b1;
      ticks(20);

      // auto-scan hit on row 3 col 5, then release
      ev(1, 3, 5);
      ticks(25);
      ev(0, 3, 5);
      ticks(12);

      // addressed reads
      AUTOSCAN = 1'b0;
      PA_SEL = 7'h42;
      ev(1, 4, 2);
      tick();
      PA_SEL = 7'h43; tick();
      PA_SEL = 7'h0C; tick();

      // links and SHIFT
      PA_SEL = 7'h02; tick();
      PA_SEL = 7'h03; tick();
      PA_SEL = 7'h00;
      ev(1, 0, 0);
      tick();
      AUTOSCAN = 1'b1;
      ticks(12);

      // ignored column, clear priority, async reset mid-scan
      ev(1, 2, 11);
      ticks(3);
      KEY_CLR = 1'b1;
      ev(1, 5, 7);
      ticks(4);
      #3 nRESET = 1'b0;
      #1;
      chk("mid_rst_col", int'(COL_OUT), 0);
      chk("mid_rst_ca2", int'(CA2), 0);
      model_reset();
      @(negedge PHI_2);
      nRESET = 1'b1;
      ticks(3);

      // rollover: nine distinct row 1-7 keys, then free one and retry the ninth
      AUTOSCAN = 1'b0;
      PA_SEL = 7'h22;
      for (int r = 1; r < 8; r++) ev(1, r, 0);
      ev(1, 1, 1);
      ev(1, 2, 2);
      tick();
      ev(0, 1, 0);
      ev(1, 2, 2);
      tick();
      AUTOSCAN = 1'b1;
      ticks(12);

      // random traffic
      for (int i = 0; i < 800; i++) begin
         KEY_STB  = ($urandom_range(0, 2) == 0);
         KEY_CLR  = ($urandom_range(0, 60) == 0);
         KEY_DOWN = ($urandom_range(0, 2) != 0);
         KEY_ROW  = 3'($urandom_range(0, 7));
         KEY_COL  = 4'($urandom_range(0, 11));
         PA_SEL   = 7'($urandom);
         if ($urandom_range(0, 19) == 0) AUTOSCAN = ~AUTOSCAN;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
